seq_pattern_gen: RTL and testbench
==================================

Name: seq_pattern_gen

Overview:
- Target-pattern source for the Precision Button Press game. It is the writer side of the sequence checker.
- Generates a pseudo-random 8-bit target and shows it on the board LEDs for a level-dependent window, then blanks the LEDs.
- Holds the target steady on TARGET for the checker, waits for the player's submit, and scores the checker's match pulse.
- Sits between the board buttons/LEDs and the sequence checker, whose LEDS input is driven by TARGET and whose Z output returns as MATCH.

Parameters:
- SHOW_BASE, 100_000_000: display-window length at level 0, in cycles.
- SHOW_STEP, 6_000_000: cycles removed from the window per level.
- SHOW_MIN, 10_000_000: floor on the display window, in cycles.
- TIMEOUT_CYC, 500_000_000: cycles allowed in WAIT before an automatic fail.
- RESULT_WIN, 12: cycles after a submit edge during which MATCH is accepted.
- MAX_LEVEL, 15: level saturation value, must be at most 15.

Ports:
- CLK  in  1  system clock; all logic is on posedge.
- RST  in  1  reset; asynchronous, active-high.
- START_BTN  in  1  raw start button, already synchronised.
- SUB_BTN  in  1  raw submit button; the same net the checker edge-detects.
- MATCH  in  1  one-cycle pulse from the checker (its Z) when the player's switches equal TARGET.
- TARGET  out  8  current target pattern to the checker; stable from NEWPAT until the next NEWPAT.
- LEDS  out  8  board LEDs: TARGET during SHOW, 0 otherwise.
- SCORE  out  8  rounds passed this game; saturates at 255.
- LEVEL  out  4  current level, 0..MAX_LEVEL.
- ACTIVE  out  1  high in NEWPAT, SHOW, WAIT and RESULT.
- PASS_P  out  1  one-cycle pulse on a successful round.
- FAIL_P  out  1  one-cycle pulse on a failed round or timeout.

Behaviour:
- Reset (asynchronous, active-high): state IDLE; all outputs 0; LFSR loads LFSR_SEED; edge-detect registers load 0; counters load 0.
- Edge detect: a registered copy of each button is kept. An edge is asserted in the cycle where button=1 and registered copy=0. This gives one cycle of latency from button to edge, matching the checker's GO timing.
- LFSR: 8-bit Galois, taps LFSR_TAPS (x^8+x^6+x^5+x^4+1), steps every cycle in all states. It never reaches 0, so the target is never 0.
- Display window: show_len = max(SHOW_MIN, SHOW_BASE − LEVEL*SHOW_STEP), computed in 32-bit unsigned arithmetic, with the subtraction clamped at SHOW_MIN before any underflow.
- IDLE:
  - On a START edge: SCORE←0, LEVEL←0, go to NEWPAT.
  - Everything else is ignored.
- NEWPAT (1 cycle): TARGET←lfsr; counter←show_len−1; go to SHOW.
- SHOW:
  - LEDS=TARGET; counter decrements each cycle.
  - At counter=0: go to WAIT; counter←TIMEOUT_CYC−1.
  - SUB_BTN edges are ignored. An early submit is not a fail.
- WAIT:
  - LEDS=0.
  - On a SUB_BTN edge: go to RESULT; counter←RESULT_WIN−1.
  - If counter reaches 0 with no edge: go to FAIL.
- RESULT:
  - MATCH=1 in any cycle: go to PASS.
  - If counter reaches 0 with no MATCH: go to FAIL.
- PASS (1 cycle):
  - PASS_P=1.
  - SCORE←SCORE+1, saturating at 255.
  - LEVEL←LEVEL+1, saturating at MAX_LEVEL.
  - Go to NEWPAT.
- FAIL (1 cycle):
  - FAIL_P=1; LEVEL←0; SCORE held for display; go to IDLE.
- MATCH outside RESULT is ignored.
- START edges outside IDLE are ignored.
- A SUB_BTN edge and a WAIT timeout in the same cycle: the submit wins.
- MATCH in the same cycle the RESULT counter reaches 0: PASS.
- RST asserted mid-round: immediate return to IDLE and reset values. No PASS_P/FAIL_P pulse is emitted.
- TARGET holds its value in IDLE after a round, so the player can compare after a fail.

Decomposition:
- Package seq_game_pkg holds:
  - the state enum {IDLE, NEWPAT, SHOW, WAIT, RESULT, PASS, FAIL};
  - LFSR_TAPS = 8'hB8;
  - LFSR_SEED = 8'hA5.
- Sub-module lfsr8 (CLK, RST, Q[7:0]): free-running Galois LFSR using the package constants. The FSM, counters and scoring stay in seq_pattern_gen.

Test Plan (SHOW_BASE=20, SHOW_STEP=4, SHOW_MIN=8, TIMEOUT_CYC=50, RESULT_WIN=12):
- Reset, then START pulse → ACTIVE rises 2 cycles after the button. TARGET equals the LFSR value at NEWPAT and is nonzero. LEDS=TARGET for exactly 20 cycles, then 0.
- In WAIT, SUB_BTN edge, then MATCH 9 cycles later → one PASS_P, SCORE=1, LEVEL=1, new TARGET. The next SHOW lasts 16 cycles.
- Submit with no MATCH for 12 cycles → FAIL_P pulse, LEVEL=0, state IDLE. SCORE and TARGET are held.
- No submit for 50 cycles in WAIT → FAIL_P. A submit pressed during SHOW is ignored and does not shorten SHOW.
- Pass 5 rounds → show length 20,16,12,8,8. Force SCORE=255 → it stays 255. LEVEL stops at MAX_LEVEL.
- Assert RST mid-SHOW → LEDS, TARGET, SCORE, LEVEL are 0 before the next clock edge, with no pulses. MATCH driven while in IDLE produces no PASS_P.

Source files
------------

// File: rtl/seq_game_pkg.sv
// seq_game_pkg: shared state encoding and LFSR constants for the button-press game
package seq_game_pkg;

    typedef enum logic [2:0] {IDLE, NEWPAT, SHOW, WAIT, RESULT, PASS, FAIL} state_t;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [7:0] LFSR_SEED = 8'hA5;

endpackage

// File: rtl/lfsr8.sv
// lfsr8: free-running 8-bit Galois LFSR; a nonzero seed keeps it off the all-zero state
module lfsr8
    import seq_game_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    output logic [7:0] Q
);

    // shift right, folding the taps back in whenever a one drops out of bit 0
    always_ff @(posedge CLK or posedge RST)
        if (RST) Q <= LFSR_SEED;
        else     Q <= Q[0] ? (Q >> 1) ^ LFSR_TAPS : Q >> 1;

endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: shows a random target, waits for the player's submit and scores the checker's match
module seq_pattern_gen
    import seq_game_pkg::*;
#(
    parameter logic [31:0] SHOW_BASE   = 32'd100_000_000,
    parameter logic [31:0] SHOW_STEP   = 32'd6_000_000,
    parameter logic [31:0] SHOW_MIN    = 32'd10_000_000,
    parameter logic [31:0] TIMEOUT_CYC = 32'd500_000_000,
    parameter logic [31:0] RESULT_WIN  = 32'd12,
    parameter logic [3:0]  MAX_LEVEL   = 4'd15
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START_BTN,
    input  logic       SUB_BTN,
    input  logic       MATCH,
    output logic [7:0] TARGET,
    output logic [7:0] LEDS,
    output logic [7:0] SCORE,
    output logic [3:0] LEVEL,
    output logic       ACTIVE,
    output logic       PASS_P,
    output logic       FAIL_P
);

    state_t      state, state_nx;
    logic [31:0] cnt, cnt_nx;
    logic [7:0]  target_nx, score_nx;
    logic [3:0]  level_nx;
    logic [7:0]  lfsr_q;
    logic        start_q, sub_q, start_e, sub_e;
    logic [31:0] dec, show_len;

    lfsr8 u_lfsr (
        .CLK (CLK),
        .RST (RST),
        .Q   (lfsr_q)
    );

    // the window shrinks per level; the clamp fires before the subtraction could wrap
    assign dec      = 32'(LEVEL) * SHOW_STEP;
    assign show_len = (SHOW_BASE > SHOW_MIN && dec < SHOW_BASE - SHOW_MIN) ? SHOW_BASE - dec : SHOW_MIN;

    // registered rising-edge pulses, one cycle behind the buttons like the checker's GO
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            start_q <= 1'b0;
            sub_q   <= 1'b0;
            start_e <= 1'b0;
            sub_e   <= 1'b0;
        end else begin
            start_q <= START_BTN;
            sub_q   <= SUB_BTN;
            start_e <= START_BTN & ~start_q;
            sub_e   <= SUB_BTN & ~sub_q;
        end

    // state, phase counter, target and scoring registers
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            state  <= IDLE;
            cnt    <= '0;
            TARGET <= '0;
            SCORE  <= '0;
            LEVEL  <= '0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            TARGET <= target_nx;
            SCORE  <= score_nx;
            LEVEL  <= level_nx;
        end

    // next-state, counter reloads and per-state outputs
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        target_nx = TARGET;
        score_nx  = SCORE;
        level_nx  = LEVEL;
        LEDS      = '0;
        ACTIVE    = 1'b0;
        PASS_P    = 1'b0;
        FAIL_P    = 1'b0;
        case (state)
            IDLE: if (start_e) begin
                score_nx = '0;
                level_nx = '0;
                state_nx = NEWPAT;
            end
            NEWPAT: begin
                ACTIVE    = 1'b1;
                target_nx = lfsr_q;
                cnt_nx    = show_len - 32'd1;
                state_nx  = SHOW;
            end
            SHOW: begin
                ACTIVE   = 1'b1;
                LEDS     = TARGET;
                state_nx = (cnt == '0) ? WAIT : SHOW;
                cnt_nx   = (cnt == '0) ? TIMEOUT_CYC - 32'd1 : cnt - 32'd1;
            end
            WAIT: begin
                ACTIVE   = 1'b1;
                state_nx = sub_e ? RESULT : (cnt == '0) ? FAIL : WAIT;
                cnt_nx   = sub_e ? RESULT_WIN - 32'd1 : cnt - 32'd1;
            end
            RESULT: begin
                ACTIVE   = 1'b1;
                state_nx = MATCH ? PASS : (cnt == '0) ? FAIL : RESULT;
                cnt_nx   = cnt - 32'd1;
            end
            PASS: begin
                PASS_P   = 1'b1;
                score_nx = (SCORE == 8'hFF) ? SCORE : SCORE + 8'd1;
                level_nx = (LEVEL >= MAX_LEVEL) ? MAX_LEVEL : LEVEL + 4'd1;
                state_nx = NEWPAT;
            end
            FAIL: begin
                FAIL_P   = 1'b1;
                level_nx = '0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: randomized rounds planned from the game rules, checked cycle by cycle
module tb_seq_pattern_gen;

    localparam int SB = 20, SS = 4, SM = 8, TO = 50, RW = 12, ML = 15;

    typedef struct {
        bit rst, st, sb, mt;
        bit act, show, pass, fail, newpat;
        int score, level;
    } item_t;

    logic       CLK = 1'b0, RST = 1'b1, START_BTN = 1'b0, SUB_BTN = 1'b0, MATCH = 1'b0;
    logic [7:0] TARGET, LEDS, SCORE;
    logic [3:0] LEVEL;
    logic       ACTIVE, PASS_P, FAIL_P;

    int    tests = 0, fails = 0;
    int    m_score = 0, m_level = 0;
    item_t plan_q[$], chk_q[$];
    item_t cur, drv;
    int    idx = 0, cyc = 0, run = 0, max_score = 0, max_level = 0;
    int    runs[$];
    int    tgt_exp = 0;

    seq_pattern_gen #(
        .SHOW_BASE   (32'(SB)),
        .SHOW_STEP   (32'(SS)),
        .SHOW_MIN    (32'(SM)),
        .TIMEOUT_CYC (32'(TO)),
        .RESULT_WIN  (32'(RW)),
        .MAX_LEVEL   (4'(ML))
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START_BTN (START_BTN),
        .SUB_BTN   (SUB_BTN),
        .MATCH     (MATCH),
        .TARGET    (TARGET),
        .LEDS      (LEDS),
        .SCORE     (SCORE),
        .LEVEL     (LEVEL),
        .ACTIVE    (ACTIVE),
        .PASS_P    (PASS_P),
        .FAIL_P    (FAIL_P)
    );

    always #5 CLK = ~CLK;

    function automatic int show_m(input int lv);
        int v = SB - lv * SS;
        return v < SM ? SM : v;
    endfunction

    function automatic logic [7:0] lfsr_at(input int n);
        logic [7:0] s = 8'hA5;
        for (int i = 0; i < n; i++) s = s[0] ? (s >> 1) ^ 8'hB8 : s >> 1;
        return s;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    function automatic item_t mk(input bit act, input bit show);
        item_t it = '{default: 0};
        it.act   = act;
        it.show  = show;
        it.score = m_score;
        it.level = m_level;
        return it;
    endfunction

    task automatic idle(input int n);
        item_t it;
        repeat (n) begin
            it = mk(0, 0);
            it.mt = ($urandom_range(1) == 0);
            plan_q.push_back(it);
        end
    endtask

    task automatic start_game();
        item_t it = mk(0, 0);
        it.st = 1;
        plan_q.push_back(it);
        plan_q.push_back(mk(0, 0));
        m_score = 0;
        m_level = 0;
    endtask

    // kind 0: pass, 1: submit without match, 2: wait timeout
    // p: WAIT cycle of the submit press (-1 = last SHOW cycle), r: RESULT cycle of MATCH
    // early: SHOW cycle of an ignored press, or -1
    task automatic round(input int kind, input int p, input int r, input int early);
        int    b  = plan_q.size();
        int    l  = show_m(m_level);
        int    wl = (kind == 2) ? TO : p + 2;
        int    rl = (kind == 0) ? r + 1 : (kind == 1) ? RW : 0;
        item_t it;
        it = mk(1, 0);
        it.newpat = 1;
        plan_q.push_back(it);
        repeat (l) plan_q.push_back(mk(1, 1));
        repeat (wl + rl) plan_q.push_back(mk(1, 0));
        for (int i = b; i < b + 1 + l + wl; i++) plan_q[i].mt = ($urandom_range(3) == 0);
        for (int i = b + 1; i < b + l; i++) plan_q[i].st = ($urandom_range(7) == 0);
        if (kind != 2) plan_q[b + 1 + l + p].sb = 1;
        if (early >= 0) plan_q[b + 1 + early].sb = 1;
        if (kind == 0) plan_q[b + 1 + l + wl + r].mt = 1;
        it = mk(0, 0);
        it.pass = (kind == 0);
        it.fail = (kind != 0);
        plan_q.push_back(it);
        if (kind == 0) begin
            if (m_score < 255) m_score++;
            if (m_level < ML) m_level++;
        end else m_level = 0;
    endtask

    task automatic partial_reset(input int k);
        item_t it = mk(1, 0);
        it.newpat = 1;
        plan_q.push_back(it);
        repeat (k) plan_q.push_back(mk(1, 1));
        it = '{default: 0};
        it.rst = 1;
        plan_q.push_back(it);
        m_score = 0;
        m_level = 0;
    endtask

    task automatic build();
        idle(2);
        start_game();
        round(0, 0, 7, -1);
        repeat (4) round(0, $urandom_range(0, 5), $urandom_range(0, RW - 1), -1);
        round(1, 3, 0, -1);
        idle(6);
        start_game();
        round(2, 0, 0, 2);
        idle(3);
        start_game();
        round(0, -1, 0, -1);
        round(0, TO - 2, RW - 1, -1);
        round(0, 2, 0, 3);
        round(1, 0, 0, -1);
        idle(2);
        start_game();
        repeat (260) round(0, $urandom_range(0, 5), $urandom_range(0, 4), -1);
        partial_reset($urandom_range(1, 7));
        idle(5);
        start_game();
        round(0, 1, 2, -1);
        round(2, 0, 0, -1);
        idle(2);
    endtask

    // cycles since reset release, used to look up the LFSR value at NEWPAT
    always @(posedge CLK or posedge RST)
        if (RST) idx <= 0;
        else     idx <= idx + 1;

    // compare every planned cycle against the DUT, half a cycle after the edge
    always @(negedge CLK) begin
        if (chk_q.size() != 0) begin
            cur = chk_q.pop_front();
            cyc++;
            if (cur.rst) tgt_exp = 0;
            chk("active", int'(ACTIVE), int'(cur.act));
            chk("leds", int'(LEDS), cur.show ? tgt_exp : 0);
            chk("target", int'(TARGET), tgt_exp);
            chk("pass_p", int'(PASS_P), int'(cur.pass));
            chk("fail_p", int'(FAIL_P), int'(cur.fail));
            chk("score", int'(SCORE), cur.score);
            chk("level", int'(LEVEL), cur.level);
            if (cur.newpat) tgt_exp = int'(lfsr_at(idx));
            if (LEDS != 0) run++;
            else if (run != 0) begin
                runs.push_back(run);
                run = 0;
            end
            if (int'(SCORE) > max_score) max_score = int'(SCORE);
            if (int'(LEVEL) > max_level) max_level = int'(LEVEL);
        end
    end

    initial begin
        build();
        repeat (3) @(posedge CLK);
        while (plan_q.size() != 0) begin
            #1;
            drv = plan_q.pop_front();
            RST = drv.rst;
            START_BTN = drv.st;
            SUB_BTN = drv.sb;
            MATCH = drv.mt;
            chk_q.push_back(drv);
            @(posedge CLK);
        end
        #1;
        START_BTN = 0;
        SUB_BTN = 0;
        MATCH = 0;
        @(negedge CLK);
        chk("lfsr_model_1", int'(lfsr_at(1)), 8'hEA);
        chk("lfsr_model_2", int'(lfsr_at(2)), 8'h75);
        chk("lfsr_model_3", int'(lfsr_at(3)), 8'h82);
        chk("show_model_l1", show_m(1), 16);
        chk("show_model_l4", show_m(4), 8);
        chk("show_runs_seen", int'(runs.size() >= 5), 1);
        if (runs.size() >= 5) begin
            chk("show_run_0", runs[0], 20);
            chk("show_run_1", runs[1], 16);
            chk("show_run_2", runs[2], 12);
            chk("show_run_3", runs[3], 8);
            chk("show_run_4", runs[4], 8);
        end
        chk("score_saturated", max_score, 255);
        chk("level_saturated", max_level, 15);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
